// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared types and constants for the fetch stall/flush controller.
//   INST_NOP     : instruction placed in IF/ID when it holds nothing real
//   PC_STEP      : sequential fetch increment
//   skid_state_e : occupancy of the 1-entry skid buffer
//   fetch_resp_t : pc+instruction pair travelling from imem into IF/ID
package fetch_stall_ctrl_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_resp_t;

    // Sequential successor, wrapping mod 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_stall_ctrl_if.sv
// Fetch-side bus: hazard controls in, imem request/response, IF/ID and
// bubble out.
//   slave  : the fetch controller
//   master : the surrounding pipeline / instruction memory
interface fetch_stall_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              load_stall;
    logic              flush;
    logic [31:0]       br_addr;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       if_id_pc;
    logic [31:0]       if_id_inst;
    logic              if_id_valid;
    logic              id_ex_bubble;

    modport slave (
        input  load_stall, flush, br_addr, imem_rdata,
        output imem_en, imem_addr, if_id_pc, if_id_inst, if_id_valid, id_ex_bubble
    );

    modport master (
        output load_stall, flush, br_addr, imem_rdata,
        input  imem_en, imem_addr, if_id_pc, if_id_inst, if_id_valid, id_ex_bubble
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// 1-entry pc+instruction skid buffer.
//   load  : capture din (a response that arrived while IF/ID was held)
//   drain : IF/ID consumed the entry this cycle
//   clear : discard the entry (flush); wins over load
//   vld   : entry present; dout : stored entry
module fetch_skid_buf
    import fetch_stall_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  fetch_resp_t din,
    output logic        vld,
    output fetch_resp_t dout
);

    skid_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= SKID_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SKID_EMPTY: if (load && !clear)  state_d = SKID_FULL;
            SKID_FULL:  if (clear || drain)  state_d = SKID_EMPTY;
            default:                         state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)               dout <= '0;
        else if (load && !clear) dout <= din;
    end

    assign vld = (state_q == SKID_FULL);

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch stall/flush controller: owns the PC, the synchronous imem request,
// a 1-entry skid buffer and the IF/ID register; drives the ID/EX bubble.
// No instruction is lost or duplicated across stalls and no wrong-path
// instruction survives a flush.
//   clk, rstn  : clock, async active-low reset
//   bus        : hazard controls, imem port, IF/ID outputs, bubble
//   stall_cnt  : saturating count of cycles stalled without flush
//   flush_cnt  : saturating count of flush cycles
module fetch_stall_ctrl
    import fetch_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
    fetch_stall_ctrl_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic        flush;
    logic        stall;      // stall that is not overridden by a flush
    logic [31:0] pc_q;
    logic [31:0] fetch_pc_q;
    logic        fetch_vld_q;

    fetch_resp_t resp;
    fetch_resp_t skid_out;
    logic        skid_vld;
    logic        skid_load;
    logic        skid_drain;

    logic [31:0] if_id_pc_q;
    logic [31:0] if_id_inst_q;
    logic        if_id_valid_q;

    assign flush = bus.flush;
    assign stall = bus.load_stall & ~bus.flush;

    // Request goes out only when the fetch stage advances; held low in reset.
    assign bus.imem_en      = rstn & ~bus.load_stall & ~bus.flush;
    assign bus.imem_addr    = pc_q[ADDR_W-1:0];
    assign bus.id_ex_bubble = bus.load_stall | bus.flush;

    // ---- request side ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q        <= RESET_PC;
            fetch_pc_q  <= '0;
            fetch_vld_q <= 1'b0;
        end else if (flush) begin
            pc_q        <= bus.br_addr;
            fetch_vld_q <= 1'b0;
        end else if (stall) begin
            fetch_vld_q <= 1'b0;
        end else begin
            fetch_pc_q  <= pc_q;
            pc_q        <= next_pc(pc_q);
            fetch_vld_q <= 1'b1;
        end
    end

    assign resp = '{pc: fetch_pc_q, inst: bus.imem_rdata};

    // A response landing while IF/ID is held is parked; it drains on the
    // first advancing cycle, which is also the cycle pc_q is re-requested,
    // so the stream resumes without a bubble.
    assign skid_load  = stall & fetch_vld_q;
    assign skid_drain = ~bus.load_stall & ~flush & skid_vld;

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .load  (skid_load),
        .drain (skid_drain),
        .clear (flush),
        .din   (resp),
        .vld   (skid_vld),
        .dout  (skid_out)
    );

    // ---- IF/ID side ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_id_pc_q    <= '0;
            if_id_inst_q  <= INST_NOP;
            if_id_valid_q <= 1'b0;
        end else if (flush) begin
            if_id_inst_q  <= INST_NOP;
            if_id_valid_q <= 1'b0;
        end else if (stall) begin
            // hold
        end else if (skid_vld) begin
            if_id_pc_q    <= skid_out.pc;
            if_id_inst_q  <= skid_out.inst;
            if_id_valid_q <= 1'b1;
        end else if (fetch_vld_q) begin
            if_id_pc_q    <= resp.pc;
            if_id_inst_q  <= resp.inst;
            if_id_valid_q <= 1'b1;
        end else begin
            if_id_inst_q  <= INST_NOP;
            if_id_valid_q <= 1'b0;
        end
    end

    assign bus.if_id_pc    = if_id_pc_q;
    assign bus.if_id_inst  = if_id_inst_q;
    assign bus.if_id_valid = if_id_valid_q;

    // ---- saturating performance counters ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // The skid only fills on a stall, and a stall never leaves a request in
    // flight, so a full skid and a live response can never coexist.
    a_skid_excl: assert property (@(posedge clk) disable iff (!rstn) !(skid_vld && fetch_vld_q));

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
module tb_fetch_stall_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] KEY  = 32'hA5A5_0000;
    localparam int          MAX16 = 65535;
    localparam int          MAX2  = 3;

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    fetch_stall_ctrl_if #(.ADDR_W(32)) bus ();
    fetch_stall_ctrl_if #(.ADDR_W(32)) bus2 ();

    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  stall_cnt2, flush_cnt2;

    fetch_stall_ctrl #(.RESET_PC(32'h0), .ADDR_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    // Narrow-counter copy fed the same controls, for saturation.
    fetch_stall_ctrl #(.RESET_PC(32'h0), .ADDR_W(32), .CNT_W(2)) dut2 (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus2),
        .stall_cnt (stall_cnt2),
        .flush_cnt (flush_cnt2)
    );

    assign bus2.load_stall = bus.load_stall;
    assign bus2.flush      = bus.flush;
    assign bus2.br_addr    = bus.br_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous imem: mem[a] = a ^ KEY, data one cycle after the request.
    always @(posedge clk) begin
        if (bus.imem_en)  bus.imem_rdata  <= bus.imem_addr ^ KEY;
        if (bus2.imem_en) bus2.imem_rdata <= bus2.imem_addr ^ KEY;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // ---- transaction-level model ----
    // Responses that IF/ID could not accept queue up in order; IF/ID takes
    // the oldest one whenever fetch advances.
    logic [31:0] m_pc;
    logic        m_infl_v;
    logic [31:0] m_infl_pc;
    logic [31:0] m_q[$];
    logic        m_v;
    logic [31:0] m_ifpc;
    int          m_s16, m_f16, m_s2, m_f2;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pc = 32'h0; m_infl_v = 1'b0; m_infl_pc = 32'h0;
            m_q.delete(); m_v = 1'b0; m_ifpc = 32'h0;
            m_s16 = 0; m_f16 = 0; m_s2 = 0; m_f2 = 0;
        end else if (bus.flush) begin
            m_q.delete();
            m_v = 1'b0;
            m_infl_v = 1'b0;
            m_pc = bus.br_addr;
            if (m_f16 < MAX16) m_f16++;
            if (m_f2 < MAX2) m_f2++;
        end else if (bus.load_stall) begin
            if (m_infl_v) m_q.push_back(m_infl_pc);
            m_infl_v = 1'b0;
            if (m_s16 < MAX16) m_s16++;
            if (m_s2 < MAX2) m_s2++;
        end else begin
            if (m_infl_v) m_q.push_back(m_infl_pc);
            if (m_q.size() > 0) begin
                m_ifpc = m_q.pop_front();
                m_v = 1'b1;
            end else begin
                m_v = 1'b0;
            end
            m_infl_v = 1'b1;
            m_infl_pc = m_pc;
            m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        chk("imem_en", 32'(bus.imem_en), 32'(rstn && !bus.load_stall && !bus.flush));
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("bubble", 32'(bus.id_ex_bubble), 32'(bus.load_stall || bus.flush));
        chk("valid", 32'(bus.if_id_valid), 32'(m_v));
        chk("inst", bus.if_id_inst, m_v ? (m_ifpc ^ KEY) : NOP);
        if (m_v) chk("pc", bus.if_id_pc, m_ifpc);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_s16));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_f16));
        chk("stall_cnt2", 32'(stall_cnt2), 32'(m_s2));
        chk("flush_cnt2", 32'(flush_cnt2), 32'(m_f2));
        chk("valid2", 32'(bus2.if_id_valid), 32'(m_v));
        if (m_v) chk("pc2", bus2.if_id_pc, m_ifpc);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---- directed stimulus with literal expectations ----
    initial begin
        rstn = 1'b0;
        bus.load_stall = 1'b0;
        bus.flush = 1'b0;
        bus.br_addr = 32'h0;
        repeat (3) tick();

        chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
        chk("rst_inst", bus.if_id_inst, NOP);
        chk("rst_pc", bus.if_id_pc, 32'h0);
        chk("rst_en", 32'(bus.imem_en), 32'h0);
        chk("rst_scnt", 32'(stall_cnt), 32'h0);

        // 1: free-running stream from RESET_PC
        rstn = 1'b1;
        #1;
        chk("t1_en", 32'(bus.imem_en), 32'h1);
        chk("t1_addr", bus.imem_addr, 32'h0);
        tick();
        chk("t1_e1_valid", 32'(bus.if_id_valid), 32'h0);
        tick();
        chk("t1_e2_valid", 32'(bus.if_id_valid), 32'h1);
        chk("t1_e2_pc", bus.if_id_pc, 32'h0);
        chk("t1_e2_inst", bus.if_id_inst, 32'hA5A5_0000);
        tick();
        chk("t1_pc4", bus.if_id_pc, 32'h4);
        tick();
        chk("t1_pc8", bus.if_id_pc, 32'h8);

        // 2: one-cycle stall while IF/ID holds 0x8
        bus.load_stall = 1'b1;
        #1;
        chk("t2_bubble", 32'(bus.id_ex_bubble), 32'h1);
        chk("t2_en", 32'(bus.imem_en), 32'h0);
        tick();
        bus.load_stall = 1'b0;
        chk("t2_hold8", bus.if_id_pc, 32'h8);
        tick();
        chk("t2_skidC", bus.if_id_pc, 32'hC);
        tick();
        chk("t2_pc10", bus.if_id_pc, 32'h10);
        chk("t2_scnt", 32'(stall_cnt), 32'h1);

        // 3: three-cycle stall
        bus.load_stall = 1'b1;
        repeat (3) tick();
        chk("t3_hold10", bus.if_id_pc, 32'h10);
        bus.load_stall = 1'b0;
        tick();
        chk("t3_pc14", bus.if_id_pc, 32'h14);
        tick();
        chk("t3_pc18", bus.if_id_pc, 32'h18);
        chk("t3_scnt", 32'(stall_cnt), 32'h4);
        chk("t3_scnt2_sat", 32'(stall_cnt2), 32'h3);

        // 4: flush to 0x100 while the skid holds 0x1C
        bus.load_stall = 1'b1;
        tick();
        bus.load_stall = 1'b0;
        bus.flush = 1'b1;
        bus.br_addr = 32'h100;
        tick();
        bus.flush = 1'b0;
        chk("t4_valid", 32'(bus.if_id_valid), 32'h0);
        chk("t4_inst", bus.if_id_inst, NOP);
        chk("t4_fcnt", 32'(flush_cnt), 32'h1);
        #1;
        chk("t4_addr", bus.imem_addr, 32'h100);
        tick();
        chk("t4_noskid", 32'(bus.if_id_valid), 32'h0);
        tick();
        chk("t4_pc100", bus.if_id_pc, 32'h100);
        chk("t4_valid100", 32'(bus.if_id_valid), 32'h1);

        // 5: stall and flush together -> flush
        bus.load_stall = 1'b1;
        bus.flush = 1'b1;
        bus.br_addr = 32'h40;
        #1;
        chk("t5_bubble", 32'(bus.id_ex_bubble), 32'h1);
        chk("t5_en", 32'(bus.imem_en), 32'h0);
        tick();
        bus.load_stall = 1'b0;
        bus.flush = 1'b0;
        chk("t5_scnt", 32'(stall_cnt), 32'h5);
        chk("t5_fcnt", 32'(flush_cnt), 32'h2);
        chk("t5_valid", 32'(bus.if_id_valid), 32'h0);
        repeat (2) tick();
        chk("t5_pc40", bus.if_id_pc, 32'h40);

        // back-to-back flushes: only the last target is fetched
        bus.flush = 1'b1;
        bus.br_addr = 32'h200;
        tick();
        bus.br_addr = 32'h300;
        tick();
        bus.flush = 1'b0;
        repeat (2) tick();
        chk("bb_pc300", bus.if_id_pc, 32'h300);
        chk("bb_fcnt", 32'(flush_cnt), 32'h4);

        // 6: reset mid-stall with the skid full
        bus.load_stall = 1'b1;
        tick();
        rstn = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.if_id_valid), 32'h0);
        chk("t6_inst", bus.if_id_inst, NOP);
        chk("t6_pc", bus.if_id_pc, 32'h0);
        chk("t6_en", 32'(bus.imem_en), 32'h0);
        chk("t6_addr", bus.imem_addr, 32'h0);
        chk("t6_scnt", 32'(stall_cnt), 32'h0);
        chk("t6_fcnt", 32'(flush_cnt), 32'h0);
        repeat (2) tick();
        bus.load_stall = 1'b0;
        rstn = 1'b1;
        repeat (2) tick();
        chk("t6_restart_v", 32'(bus.if_id_valid), 32'h1);
        chk("t6_restart_pc", bus.if_id_pc, 32'h0);

        // 2-bit counter saturation: 5 stall cycles
        bus.load_stall = 1'b1;
        repeat (5) tick();
        chk("sat_scnt2", 32'(stall_cnt2), 32'h3);
        chk("sat_scnt16", 32'(stall_cnt), 32'h5);
        bus.load_stall = 1'b0;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
